// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: widths, op codes,
// FSM state codes and the largest per-pass step.
package shift_seq_ctrl_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned AMT_W    = 5;
  localparam int unsigned STEP_W   = 2;
  localparam int unsigned STEP_MAX = 3;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bus of the shift sequencer.
//   start  : request strobe (sampled only while idle)
//   op     : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amount : shift amount 0..31
//   d_in   : operand
//   d_out  : result register
//   busy   : high while a request is in flight (SHIFT and DONE)
//   done   : one-cycle pulse, d_out valid
interface shift_seq_ctrl_if;
  import shift_seq_ctrl_pkg::*;

  logic                 start;
  logic [1:0]           op;
  logic [AMT_W-1:0]     amount;
  logic [WIDTH-1:0]     d_in;
  logic [WIDTH-1:0]     d_out;
  logic                 busy;
  logic                 done;

  modport master (output start, op, amount, d_in, input d_out, busy, done);
  modport slave  (input start, op, amount, d_in, output d_out, busy, done);
endinterface

// File: rtl/shift_seq_ctrl_shift_step.sv
// Combinational step shifter: moves the operand 0..3 positions in one pass.
//   d_in_i  : operand
//   op_i    : shift kind, selects the fill for vacated bits
//   shamt_i : step size 0..3
//   d_out_o : shifted result (combinational)
module shift_step
  import shift_seq_ctrl_pkg::*;
(
  input  logic [WIDTH-1:0]  d_in_i,
  input  op_e               op_i,
  input  logic [STEP_W-1:0] shamt_i,
  output logic [WIDTH-1:0]  d_out_o
);

  // Fixed-distance shift; k is always a constant at the call sites.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input op_e op,
                                                input int unsigned k);
    logic [WIDTH-1:0] r;
    case (op)
      OP_LSL:  r = d << k;
      OP_LSR:  r = d >> k;
      OP_ASR:  r = WIDTH'($signed(d) >>> k);
      default: r = (d >> k) | (d << (WIDTH - k));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] s1_c, s2_c, s3_c;

  always_comb begin
    s1_c = shift_by(d_in_i, op_i, 1);
    s2_c = shift_by(d_in_i, op_i, 2);
    s3_c = shift_by(d_in_i, op_i, 3);
  end

  // One 4:1 mux per bit, selected by the step size.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign d_out_o[i] = (shamt_i == 2'd0) ? d_in_i[i] :
                        (shamt_i == 2'd1) ? s1_c[i]   :
                        (shamt_i == 2'd2) ? s2_c[i]   : s3_c[i];
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: performs a 32-bit shift of 0..31 positions by
// iterating passes of at most three positions through shift_step.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : request/response interface (slave side)
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  shift_seq_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  op_e                op_q, op_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [STEP_W-1:0]  step_c;
  logic [WIDTH-1:0]   step_out_c;

  // Largest step the shifter can take this pass.
  assign step_c = (rem_q >= AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX) : rem_q[STEP_W-1:0];

  shift_step u_step (
    .d_in_i  (data_q),
    .op_i    (op_q),
    .shamt_i (step_c),
    .d_out_o (step_out_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      op_q    <= OP_LSL;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath update and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          data_d  = bus.d_in;
          op_d    = op_e'(bus.op);
          rem_d   = bus.amount;
          state_d = (bus.amount != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        data_d  = step_out_c;
        rem_d   = rem_q - AMT_W'(step_c);
        state_d = (rem_d == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Handshake flags track the state being entered so they are registered.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign bus.d_out = data_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, random
// requests against a whole-shift reference model, and handshake corner cases.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] d;
    logic [31:0] exp;
    int          n;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Whole-shift reference computed directly from the shift definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                            input logic [31:0] d);
    logic [31:0] r;
    int unsigned a;
    a = int'(amt);
    case (op)
      2'b00:   r = d << a;
      2'b01:   r = d >> a;
      2'b10:   r = 32'($signed(d) >>> a);
      default: r = (a == 0) ? d : ((d >> a) | (d << (32 - a)));
    endcase
    return r;
  endfunction

  function automatic int passes(input logic [4:0] amt);
    return (int'(amt) + 2) / 3;
  endfunction

  // Issue one request and check latency, result and handshake shape.
  task automatic run_req(input string nm, input logic [1:0] op, input logic [4:0] amt,
                         input logic [31:0] d, input logic [31:0] exp, input int n);
    int lat;
    logic busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.amount = amt; bus.d_in = d;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.d_in = ~d;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(n));
    check({nm, " result"}, bus.d_out, exp);
    check({nm, " busy"}, {31'd0, busy_ok & bus.busy}, 32'd1);
    @(negedge clk);
    check({nm, " idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({nm, " hold"}, bus.d_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [1:0]  rop;
    logic [4:0]  ramt;
    logic [31:0] rd;

    vecs[0] = '{"lsr0",   2'b01, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 0};
    vecs[1] = '{"lsr31",  2'b01, 5'd31, 32'h80000000, 32'h00000001, 11};
    vecs[2] = '{"asr4",   2'b10, 5'd4,  32'hF0000000, 32'hFF000000, 2};
    vecs[3] = '{"lsl5",   2'b00, 5'd5,  32'h00000001, 32'h00000020, 2};
    vecs[4] = '{"ror8",   2'b11, 5'd8,  32'h12345678, 32'h78123456, 3};
    vecs[5] = '{"ror31",  2'b11, 5'd31, 32'h00000001, 32'h00000002, 11};
    vecs[6] = '{"asr31",  2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 11};
    vecs[7] = '{"lsl3",   2'b00, 5'd3,  32'h00000001, 32'h00000008, 1};
    vecs[8] = '{"lsl1",   2'b00, 5'd1,  32'h80000001, 32'h00000002, 1};
    vecs[9] = '{"ror0",   2'b11, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0};

    bus.start = 1'b0; bus.op = 2'b00; bus.amount = '0; bus.d_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {bus.d_out[29:0], bus.busy, bus.done}, 32'd0);
    check("reset d_out", bus.d_out, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++)
      run_req(vecs[i].name, vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].exp, vecs[i].n);

    // Start pulses while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.amount = 5'd6; bus.d_in = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.op = 2'b00; bus.amount = 5'd1; bus.d_in = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done) begin
        dones++;
        check("busy start result", bus.d_out, 32'h03FFFFFF);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    check("busy start done count", 32'(dones), 32'd1);
    check("busy start idle", {30'd0, bus.busy, bus.done}, 32'd0);
    check("busy start hold", bus.d_out, 32'h03FFFFFF);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.amount = 5'd31; bus.d_in = 32'hFFFF0000;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset d_out", bus.d_out, 32'd0);
    check("mid reset flags", {30'd0, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("mid reset no done", 32'(dones), 32'd0);
    run_req("after reset lsr2", 2'b01, 5'd2, 32'h8, 32'h2, 1);

    // Random requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ramt = 5'($urandom_range(0, 31));
      rd   = $urandom;
      if (i % 8 == 0) rd = 32'h80000001;
      run_req($sformatf("rand%0d", i), rop, ramt, rd, ref_shift(rop, ramt, rd), passes(ramt));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
